// File: rtl/scs8hd_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scs8hd_bist_pkg
// Purpose  : Shared definitions for the a221o cell BIST controller:
//            controller state encoding, vector sizing, MISR polynomial and
//            seed, and the golden a221o function X = (A1&A2)|(B1&B2)|C1.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package scs8hd_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

  localparam int VEC_W     = 5;
  localparam int VEC_COUNT = 32;

  // x^16 + x^14 + x^13 + x^11 + 1 : taps at bits 14, 13, 11 and 0.
  localparam logic [15:0] MISR_POLY = 16'h6801;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // Vector bit order is {C1,B2,B1,A2,A1}.
  function automatic logic a221o_golden(input logic [VEC_W-1:0] vec);
    return (vec[0] & vec[1]) | (vec[2] & vec[3]) | vec[4];
  endfunction

endpackage : scs8hd_bist_pkg
`default_nettype wire

// File: rtl/scs8hd_bist_misr.sv
`default_nettype none
// ============================================================================
// Module   : scs8hd_bist_misr
// Purpose  : 16-bit single-input signature register (Galois form, shifting
//            toward the MSB) compacting the sampled X stream.
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset (register -> seed)
//            load      - reseed the register
//            shift     - fold din into the signature
//            din       - serial input bit
//            signature - current register contents
// Revision : 1.0  initial release
// ============================================================================
module scs8hd_bist_misr
  import scs8hd_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic        din,
  output logic [15:0] signature
);

  logic feedback;

  // The incoming bit is combined with the bit leaving the top of the register.
  assign feedback = signature[15] ^ din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= MISR_SEED;
    end else if (load) begin
      signature <= MISR_SEED;
    end else if (shift) begin
      signature <= {signature[14:0], 1'b0} ^ ({16{feedback}} & MISR_POLY);
    end
  end

endmodule : scs8hd_bist_misr
`default_nettype wire

// File: rtl/scs8hd_a221o_bist.sv
`default_nettype none
// ============================================================================
// Module   : scs8hd_a221o_bist
// Purpose  : Built-in self-test controller for an a221o cell. Walks all 32
//            input vectors onto the cell, samples X at the end of each
//            settle window, compares with the golden function and reports a
//            saturating mismatch count plus pass/fail.
// Macro    : SC_BIST_MISR_EN - adds a 16-bit MISR and the SIGNATURE port.
// Params   : SETTLE_CYCLES (0..15) extra hold cycles per vector
//            FAIL_W        width of FAIL_COUNT
// Ports    : CLK, RESET_B (async active-low), START, X (cell output)
//            A1, A2, B1, B2, C1 - stimulus to the cell
//            BUSY, DONE, PASS, FAIL_COUNT, SIGNATURE (macro only)
// Revision : 1.0  initial release
// ============================================================================
module scs8hd_a221o_bist
  import scs8hd_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int FAIL_W        = 6
) (
  input  logic              CLK,
  input  logic              RESET_B,
  input  logic              START,
  input  logic              X,
  output logic              A1,
  output logic              A2,
  output logic              B1,
  output logic              B2,
  output logic              C1,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [FAIL_W-1:0] FAIL_COUNT
`ifdef SC_BIST_MISR_EN
  ,
  output logic [15:0]       SIGNATURE
`endif
);

  bist_state_e        state;
  logic [VEC_W-1:0]   vec;
  logic [3:0]         settle;
  logic [VEC_W-1:0]   stim;

  logic               accept;
  logic               sample_now;
  logic               mismatch;
  logic [FAIL_W-1:0]  fail_next;

  // START is only honoured outside a run; a held START cannot retrigger RUN.
  assign accept     = START && (state != ST_RUN);
  // Last edge of the current vector's hold window.
  assign sample_now = (state == ST_RUN) && (settle == 4'(SETTLE_CYCLES));
  assign mismatch   = sample_now && (X != a221o_golden(vec));

  // Saturating increment: stops at all-ones.
  always_comb begin
    fail_next = FAIL_COUNT;
    if (mismatch && (FAIL_COUNT != {FAIL_W{1'b1}})) begin
      fail_next = FAIL_COUNT + FAIL_W'(1);
    end
  end

  assign {C1, B2, B1, A2, A1} = stim;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state      <= ST_IDLE;
      vec        <= '0;
      settle     <= '0;
      stim       <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      FAIL_COUNT <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state      <= ST_RUN;
            vec        <= '0;
            settle     <= '0;
            stim       <= '0;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            FAIL_COUNT <= '0;
          end
        end
        ST_RUN: begin
          FAIL_COUNT <= fail_next;
          if (sample_now) begin
            settle <= '0;
            if (vec == VEC_W'(VEC_COUNT - 1)) begin
              state <= ST_DONE;
              vec   <= '0;
              stim  <= '0;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              // Uses the count including this final comparison.
              PASS  <= (fail_next == '0);
            end else begin
              vec  <= vec + VEC_W'(1);
              stim <= vec + VEC_W'(1);
            end
          end else begin
            settle <= settle + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SC_BIST_MISR_EN
  scs8hd_bist_misr u_misr (
    .clk       (CLK),
    .rst_n     (RESET_B),
    .load      (accept),
    .shift     (sample_now),
    .din       (X),
    .signature (SIGNATURE)
  );
`endif

endmodule : scs8hd_a221o_bist
`default_nettype wire

// File: tb/tb_scs8hd_a221o_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_scs8hd_a221o_bist
// Purpose  : Self-checking bench for scs8hd_a221o_bist. The cell under test
//            is modelled here with optional per-vector output inversion or
//            stuck-at behaviour; expected counts and signatures are derived
//            from the a221o truth table. A second instance with FAIL_W=3 and
//            X tied low exercises counter saturation alongside every run.
// Revision : 1.0  initial release
// ============================================================================
module tb_scs8hd_a221o_bist;

  localparam int S   = 1;
  localparam int WIN = 32 * (S + 1);

  logic        CLK = 1'b0;
  logic        RESET_B = 1'b0;
  logic        START = 1'b0;
  logic        X;
  logic        A1, A2, B1, B2, C1, BUSY, DONE, PASS;
  logic [5:0]  FAIL_COUNT;
  logic        zero_x = 1'b0;
  logic        A1s, A2s, B1s, B2s, C1s, BUSYs, DONEs, PASSs;
  logic [2:0]  FAIL_COUNTs;
`ifdef SC_BIST_MISR_EN
  logic [15:0] SIGNATURE, SIGNATUREs;
`endif
  logic [4:0]  stim;

  int          x_mode = 0;        // 0: golden ^ err_mask, 1: stuck 0, 2: stuck 1
  logic [31:0] err_mask = '0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] last_sig;

  scs8hd_a221o_bist #(.SETTLE_CYCLES(S), .FAIL_W(6)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .START(START), .X(X),
    .A1(A1), .A2(A2), .B1(B1), .B2(B2), .C1(C1),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .FAIL_COUNT(FAIL_COUNT)
`ifdef SC_BIST_MISR_EN
    , .SIGNATURE(SIGNATURE)
`endif
  );

  scs8hd_a221o_bist #(.SETTLE_CYCLES(S), .FAIL_W(3)) dut_sat (
    .CLK(CLK), .RESET_B(RESET_B), .START(START), .X(zero_x),
    .A1(A1s), .A2(A2s), .B1(B1s), .B2(B2s), .C1(C1s),
    .BUSY(BUSYs), .DONE(DONEs), .PASS(PASSs), .FAIL_COUNT(FAIL_COUNTs)
`ifdef SC_BIST_MISR_EN
    , .SIGNATURE(SIGNATUREs)
`endif
  );

  always #5 CLK = ~CLK;

  assign stim = {C1, B2, B1, A2, A1};

  function automatic logic golden(input int v);
    return (((v % 2) == 1) && (((v / 2) % 2) == 1)) ||
           ((((v / 4) % 2) == 1) && (((v / 8) % 2) == 1)) ||
           (v >= 16);
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15] ^ d) n = n ^ 16'h6801;
    return n;
  endfunction

  // Behavioural cell under test.
  always_comb begin
    X = 1'b0;
    case (x_mode)
      1: X = 1'b0;
      2: X = 1'b1;
      default: X = golden(int'(stim)) ^ err_mask[stim];
    endcase
  end

  // One complete run from START to DONE, checked cycle by cycle.
  task automatic run_check(input string name, input int mode, input logic [31:0] mask,
                           input bit hold);
    int          exp_fc;
    logic [15:0] exp_sig;
    logic        xk;
    x_mode  = mode;
    err_mask = mask;
    exp_fc  = 0;
    exp_sig = 16'hFFFF;
    for (int k = 0; k < 32; k++) begin
      xk = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (golden(k) ^ mask[k]);
      if (xk != golden(k)) exp_fc++;
      exp_sig = misr_step(exp_sig, xk);
    end
    if (exp_fc > 63) exp_fc = 63;

    @(negedge CLK);
    START = 1'b1;
    for (int j = 0; j <= WIN; j++) begin
      @(negedge CLK);
      if (!hold) START = 1'b0;
      if (j == 0) begin
        vectors++;
        if (DONE !== 1'b0 || PASS !== 1'b0 || FAIL_COUNT !== 6'd0) begin
          miscompares++;
          $display("FAIL %s start_clear: DONE=%b PASS=%b FAIL_COUNT=%0d, need 0/0/0",
                   name, DONE, PASS, FAIL_COUNT);
        end
      end
      if (j < WIN) begin
        vectors++;
        if (BUSY !== 1'b1 || DONE !== 1'b0 || stim !== 5'(j / (S + 1))) begin
          miscompares++;
          $display("FAIL %s cycle%0d: BUSY=%b DONE=%b vec=%0d, need 1/0/%0d",
                   name, j, BUSY, DONE, stim, j / (S + 1));
        end
      end else begin
        vectors++;
        if (BUSY !== 1'b0 || DONE !== 1'b1 || stim !== 5'd0 ||
            PASS !== (exp_fc == 0) || FAIL_COUNT !== 6'(exp_fc)) begin
          miscompares++;
          $display("FAIL %s result: BUSY=%b DONE=%b vec=%0d PASS=%b FAIL_COUNT=%0d, need 0/1/0/%b/%0d",
                   name, BUSY, DONE, stim, PASS, FAIL_COUNT, exp_fc == 0, exp_fc);
        end
        vectors++;
        if (DONEs !== 1'b1 || PASSs !== 1'b0 || FAIL_COUNTs !== 3'd7) begin
          miscompares++;
          $display("FAIL %s saturation: DONE=%b PASS=%b FAIL_COUNT=%0d, need 1/0/7",
                   name, DONEs, PASSs, FAIL_COUNTs);
        end
`ifdef SC_BIST_MISR_EN
        vectors++;
        if (SIGNATURE !== exp_sig) begin
          miscompares++;
          $display("FAIL %s signature: got %h, need %h", name, SIGNATURE, exp_sig);
        end
        last_sig = SIGNATURE;
`endif
      end
    end
    START = 1'b0;
    @(negedge CLK);
    vectors++;
    if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_hold: DONE=%b BUSY=%b, need 1/0", name, DONE, BUSY);
    end
  endtask

  task automatic check_reset_values(input string name);
    vectors++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || PASS !== 1'b0 || FAIL_COUNT !== 6'd0 ||
        stim !== 5'd0) begin
      miscompares++;
      $display("FAIL %s: BUSY=%b DONE=%b PASS=%b FAIL_COUNT=%0d vec=%0d, need all 0",
               name, BUSY, DONE, PASS, FAIL_COUNT, stim);
    end
`ifdef SC_BIST_MISR_EN
    vectors++;
    if (SIGNATURE !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL %s signature: got %h, need ffff", name, SIGNATURE);
    end
`endif
  endtask

  task automatic test_reset();
    RESET_B = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_values("reset_held");
    RESET_B = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_golden();
    run_check("golden", 0, 32'h0, 1'b0);
  endtask

  task automatic test_stuck();
    run_check("stuck0", 1, 32'h0, 1'b0);
    run_check("stuck1", 2, 32'h0, 1'b0);
  endtask

  task automatic test_random_faults();
    logic [31:0] m;
    for (int r = 0; r < 3; r++) begin
      m = $urandom();
      if (r == 2) m = m & $urandom() & $urandom();
      run_check("random", 0, m, 1'b0);
    end
  endtask

  task automatic test_start_hold();
    run_check("start_hold", 0, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] first_sig;
    run_check("b2b_first", 0, 32'h0, 1'b0);
    first_sig = last_sig;
    run_check("b2b_second", 0, 32'h0, 1'b0);
`ifdef SC_BIST_MISR_EN
    vectors++;
    if (last_sig !== first_sig) begin
      miscompares++;
      $display("FAIL b2b_sig_equal: got %h, need %h", last_sig, first_sig);
    end
    run_check("flip5", 0, 32'h0000_0020, 1'b0);
    vectors++;
    if (last_sig === first_sig) begin
      miscompares++;
      $display("FAIL flip5_sig_differs: got %h, need not %h", last_sig, first_sig);
    end
`else
    run_check("flip5", 0, 32'h0000_0020, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_run();
    bit found;
    x_mode   = 0;
    err_mask = 32'h0000_03FF;   // mismatches on 0..9 so the count is non-zero
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (BUSY === 1'b1 && stim === 5'd10) found = 1'b1;
      else @(negedge CLK);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL reach_vec10: vec=%0d BUSY=%b, need vec 10 within 100 cycles", stim, BUSY);
    end
    vectors++;
    if (FAIL_COUNT !== 6'd10) begin
      miscompares++;
      $display("FAIL pre_reset_count: got %0d, need 10", FAIL_COUNT);
    end
    #2;
    RESET_B = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge CLK);
    RESET_B = 1'b1;
    @(negedge CLK);
    check_reset_values("post_abort_idle");
    run_check("after_abort", 0, 32'h0, 1'b0);
  endtask

  initial begin
    last_sig = '0;
    test_reset();
    test_golden();
    test_stuck();
    test_random_faults();
    test_start_hold();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_scs8hd_a221o_bist
`default_nettype wire
